// File: rtl/seq_req_pkg.sv
// Shared types and helpers for the 4-port request generator / grant checker.
package seq_req_pkg;

    localparam int unsigned NPORTS = 4;

    typedef logic [NPORTS-1:0] port_vec_t;

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input port_vec_t vec);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < int'(NPORTS); i++) begin
            if (vec[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        return multi;
    endfunction

endpackage

// File: rtl/seq_req_port.sv
// One requester port: pending-request count, served counter, wait/starve tracking.
module seq_req_port #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             grant_valid,
    input  logic             spurious,
    input  logic             clear,
    output logic             req,
    output logic             full,
    output logic [CNT_W-1:0] served,
    output logic             starve
);

    localparam int unsigned PEND_W = $clog2(DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  SERVED_MAX = '1;

    logic [PEND_W-1:0] pending, pending_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0]  served_nxt;
    logic              starve_nxt;
    logic              consume;

    assign req  = (pending != '0);
    assign full = (pending == PEND_MAX);

    // A grant flagged spurious must never move port state.
    assign consume = grant_valid & ~spurious;

    always_comb begin
        pending_nxt = pending;
        served_nxt  = served;
        wait_nxt    = '0;
        starve_nxt  = starve;

        if (push && !consume) begin
            if (!full) pending_nxt = pending + PEND_W'(1);
        end else if (consume && !push) begin
            pending_nxt = pending - PEND_W'(1);
        end

        if (consume && (served != SERVED_MAX)) served_nxt = served + CNT_W'(1);

        if (req && !consume) begin
            wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
        if (wait_nxt == WAIT_MAX) starve_nxt = 1'b1;

        // Clear wins over any same-cycle increment; pending is deliberately kept.
        if (clear) begin
            served_nxt = '0;
            wait_nxt   = '0;
            starve_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            served   <= '0;
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            served   <= served_nxt;
            wait_cnt <= wait_nxt;
            starve   <= starve_nxt;
        end
    end

endmodule

// File: rtl/seq_req_gen_4port.sv
// Requester endpoint for a 4-input arbiter: drives reqs, checks grants, counts service.
module seq_req_gen_4port
    import seq_req_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       push,
    input  logic [3:0]       grants,
    input  logic             clear,
    input  logic [1:0]       served_sel,
    output logic [3:0]       reqs,
    output logic [3:0]       full,
    output logic [CNT_W-1:0] served_cnt,
    output logic [3:0]       starve,
    output logic             err_spurious,
    output logic             err_multi
);

    port_vec_t        grant_valid;
    port_vec_t        spurious_vec;
    logic             multi;
    logic [CNT_W-1:0] served [NPORTS];

    // Grant checker: a multi-hot vector is consumed by nobody.
    always_comb begin
        multi        = multi_hot(grants);
        spurious_vec = grants & ~reqs;
        grant_valid  = multi ? '0 : (grants & reqs);
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        seq_req_port #(
            .DEPTH        (DEPTH),
            .CNT_W        (CNT_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_port (
            .clk         (clk),
            .reset_n     (reset_n),
            .push        (push[i]),
            .grant_valid (grant_valid[i]),
            .spurious    (spurious_vec[i]),
            .clear       (clear),
            .req         (reqs[i]),
            .full        (full[i]),
            .served      (served[i]),
            .starve      (starve[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_spurious <= 1'b0;
            err_multi    <= 1'b0;
        end else if (clear) begin
            err_spurious <= 1'b0;
            err_multi    <= 1'b0;
        end else begin
            if (|spurious_vec) err_spurious <= 1'b1;
            if (multi)         err_multi    <= 1'b1;
        end
    end

    assign served_cnt = served[served_sel];

endmodule

// File: doc/seq_req_gen_4port.md
Name: seq_req_gen_4port

Overview:
- Requester-side endpoint of the 4-port req/grant interface used by the weighted arbiters.
- Holds a queue of pending requests per port and drives reqs[3:0] to the arbiter.
- Consumes the arbiter's same-cycle grants[3:0] and counts grants served per port.
- Flags protocol violations and starvation, so it doubles as a bench-side traffic source and checker for any 4-input arbiter.

Parameters:
- DEPTH, 4: maximum pending requests per port (1..15).
- CNT_W, 8: width of the per-port served counters.
- STARVE_LIMIT, 16: consecutive requesting-but-ungranted cycles before starve is flagged (>=2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- push  input  4  push[i]=1 adds one pending request to port i.
- grants  input  4  grant vector from the arbiter, same cycle as reqs.
- clear  input  1  synchronous clear of statistics and error flags.
- served_sel  input  2  selects the port shown on served_cnt.
- reqs  output  4  reqs[i]=1 when port i has pending>0.
- full  output  4  full[i]=1 when pending[i]==DEPTH.
- served_cnt  output  CNT_W  served counter of port served_sel.
- starve  output  4  sticky; port i waited STARVE_LIMIT cycles.
- err_spurious  output  1  sticky; a grant arrived on a non-requesting port.
- err_multi  output  1  sticky; more than one grant bit was set in a cycle.

Behaviour:
- reset_n=0 (asynchronous): every pending, served, wait, starve and error register goes to 0. Hence reqs=0, full=0, served_cnt=0, starve=0, err_*=0 immediately and for as long as reset_n is low.
- Register widths: pending is clog2(DEPTH+1) bits; wait is clog2(STARVE_LIMIT+1) bits.
- reqs[i] and full[i] are decoded from registered pending[i] only; there is no combinational path from any input.
- served_cnt is a combinational mux of served[served_sel].
- Valid grant, per port per cycle: grants[i]=1 and reqs[i]=1 and exactly one grants bit set.
- Pending update at each edge, per port:
  - push and valid grant: pending unchanged.
  - push only: pending+1, or dropped silently if full[i].
  - valid grant only: pending-1.
- Served counter: a valid grant increments served[i], saturating at 2^CNT_W-1 (no wrap).
- Spurious grant: grants[i]=1 with reqs[i]=0 sets err_spurious and changes no port state.
- Multiple grants: popcount(grants)>1 sets err_multi. In that cycle no grant is consumed on any port; pushes still apply. Spurious bits within the same vector also set err_spurious.
- Wait counter, per port:
  - reqs[i]=1 without a valid grant: wait[i] increments, saturating at STARVE_LIMIT.
  - Valid grant or reqs[i]=0: wait[i] clears to 0.
  - The edge on which wait[i] reaches STARVE_LIMIT sets starve[i]; starve is visible the following cycle.
- clear=1 (synchronous): served, wait, starve and err_* go to 0. pending is untouched. clear takes priority over any increment or flag set in the same cycle.
- Reset mid-operation discards all pending requests; the arbiter then sees reqs=0 from the moment reset asserts.

Decomposition:
- Package seq_req_pkg:
  - NPORTS=4 constant.
  - typedef for the 4-bit port vector.
  - function for one-hot/popcount>1 detection.
- Sub-module seq_req_port, instantiated 4 times. It holds pending, served and wait for one port.
  - Inputs: push, grant_valid, spurious, clear.
  - Outputs: req, full, served, starve.
- The top level holds the grant checker, error flags and served_cnt mux.

Test Plan:
- Pushes and grants on a single port:
  - push=0001 for 1 cycle, then grants=0001 one cycle later -> reqs 0001 then 0000; served_sel=0 shows served_cnt=1; no errors.
  - push=0010 each cycle for 5 cycles, no grants -> full=0010 after 4 pushes, 5th push dropped, pending stays 4.
- Simultaneous push and grant on port 2 with pending=2 -> reqs[2] stays 1, pending stays 2, served[2]=1.
- grants=0011 while reqs=0011 -> err_multi=1 next cycle, pending unchanged on both ports; grants=1000 with reqs[3]=0 -> err_spurious=1.
- Port 3 held requesting with no grants for 16 cycles -> starve=1000 after the 16th edge; clear=1 -> starve=0, err_*=0, reqs still 1000.
- Connected to the weighted 4-input arbiter with push=1111 every cycle for 14 cycles -> served counts match the arbiter's weight ratio, err_*=0. reset_n pulsed low mid-run -> reqs=0 asynchronously and all counters 0.
